// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM-state definitions for the sequential ALU and the
// blocks that consume its outputs.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// WIDTH-iteration shift-add multiplier: load latches the operands, each step
// retires one multiplier bit; product is valid after WIDTH steps.
module shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     upper_sum;

  // The multiplier sits in the low half and is consumed LSB-first as the
  // accumulator shifts right; the add carry becomes the new MSB.
  always_comb begin
    upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand_q} : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand_q <= '0;
    end else if (load) begin
      acc     <= {{WIDTH{1'b0}}, mplier};
      mcand_q <= mcand;
    end else if (step) begin
      acc     <= {upper_sum, acc[WIDTH-1:1]};
    end
  end

  assign product = acc;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: one operation per accepted start, registered result and
// cf/sf/zf held between operations for a downstream flag register.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             sf,
  output logic             zf
);

  // Handshake: start is sampled only on edges where busy=0; done is a single
  // cycle pulse on which result/flags have just been updated.

  state_t           state, state_n;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [SHW:0]     cnt, cnt_load;
  logic [WIDTH-1:0] sh;
  logic             sout;
  logic             accept, run_step;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] fin_res;
  logic             fin_cf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN:   if (cnt == '0) state_n = S_FIN;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign accept   = (state == S_IDLE) && start;
  assign run_step = (state == S_RUN) && (cnt != '0);
  assign busy     = (state != S_IDLE);

  always_comb begin
    cnt_load = '0;
    if (op == OP_SHL || op == OP_SHR) cnt_load = {1'b0, b[SHW-1:0]};
    else if (op == OP_MUL)            cnt_load = (SHW+1)'(WIDTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
      sh   <= '0;
      sout <= 1'b0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
      cnt  <= cnt_load;
      sh   <= a;
      sout <= 1'b0;
    end else if (run_step) begin
      cnt <= cnt - 1'b1;
      if (op_q == OP_SHL) begin
        sh   <= {sh[WIDTH-2:0], 1'b0};
        sout <= sh[WIDTH-1];
      end else if (op_q == OP_SHR) begin
        sh   <= {1'b0, sh[WIDTH-1:1]};
        sout <= sh[0];
      end
    end
  end

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .step    (run_step && (op_q == OP_MUL)),
    .mcand   (a),
    .mplier  (b),
    .product (product)
  );

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    fin_res = '0;
    fin_cf  = 1'b0;
    case (op_q)
      OP_ADD: begin fin_res = sum[WIDTH-1:0]; fin_cf = sum[WIDTH]; end
      OP_SUB: begin fin_res = a_q - b_q;      fin_cf = (a_q < b_q); end
      OP_AND: fin_res = a_q & b_q;
      OP_OR:  fin_res = a_q | b_q;
      OP_XOR: fin_res = a_q ^ b_q;
      OP_SHL, OP_SHR: begin fin_res = sh; fin_cf = sout; end
      OP_MUL: begin
        fin_res = product[WIDTH-1:0];
        fin_cf  = |product[2*WIDTH-1:WIDTH];
      end
      default: fin_res = '0;
    endcase
  end

  // Outputs move only on the FIN edge, so they stay stable for sampling
  // every clock without an enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= '0;
      cf     <= 1'b0;
      sf     <= 1'b0;
      zf     <= 1'b0;
    end else begin
      done <= (state == S_FIN);
      if (state == S_FIN) begin
        result <= fin_res;
        cf     <= fin_cf;
        sf     <= fin_res[WIDTH-1];
        zf     <= (fin_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed plan vectors, random
// operations against an arithmetic reference model, and handshake corners.
module tb_seq_alu;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       busy, done, cf, sf, zf;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cf(cf), .sf(sf), .zf(zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {cf, sf, zf, result} straight from the arithmetic definitions.
  function automatic logic [10:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] w;
    logic [7:0]  r;
    logic        c;
    int          k;
    k = int'(y[2:0]);
    c = 1'b0;
    r = 8'h00;
    case (o)
      3'd0: begin w = 16'(x) + 16'(y); r = w[7:0]; c = w[8]; end
      3'd1: begin r = x - y; c = (x < y); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin w = 16'(x) << k; r = w[7:0]; if (k != 0) c = w[8]; end
      3'd6: begin r = x >> k; if (k != 0) c = x[k-1]; end
      default: begin w = 16'(x) * 16'(y); r = w[7:0]; c = (w[15:8] != 8'h00); end
    endcase
    return {c, r[7], (r == 8'h00), r};
  endfunction

  function automatic int latency(input logic [2:0] o, input logic [7:0] y);
    if (o == 3'd5 || o == 3'd6) return 2 + int'(y[2:0]);
    if (o == 3'd7) return 10;
    return 2;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input string name);
    logic [10:0] exp_v;
    logic [7:0]  held;
    int          exp_lat, edges;
    bit          seen;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(model(o, x, y));
    exp_lat = latency(o, y);
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom_range(0, 7)); a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
    edges = 0;
    seen = 1'b0;
    while (!seen && edges < 40) begin
      if (done) seen = 1'b1;
      else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy: got %b exp 1 at edge %0d", name, busy, edges);
        end
        @(posedge clk); #1;
        edges++;
      end
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no done within 40 edges", name);
      return;
    end
    if (edges != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d exp %0d", name, edges, exp_lat);
    end
    checks++;
    if ({cf, sf, zf, result} !== exp_v) begin
      errors++;
      $display("FAIL %s result: got cf=%b sf=%b zf=%b r=%h exp cf=%b sf=%b zf=%b r=%h",
               name, cf, sf, zf, result, exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b exp 0", name, busy);
    end
    held = result;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || result !== exp_v[7:0]) begin
      errors++;
      $display("FAIL %s hold: got done=%b r=%h exp done=0 r=%h", name, done, result, exp_v[7:0]);
    end
    if (held !== result) ;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, result, cf, sf, zf} !== 13'h0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b r=%h cf=%b sf=%b zf=%b exp all 0",
               busy, done, result, cf, sf, zf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(3'd0, 8'hFF, 8'h01, "add_ff_01");
    run_op(3'd1, 8'h03, 8'h05, "sub_3_5");
    run_op(3'd1, 8'h05, 8'h05, "sub_5_5");
    run_op(3'd5, 8'h81, 8'h01, "shl_81_1");
    run_op(3'd6, 8'h01, 8'h00, "shr_01_0");
    run_op(3'd6, 8'hB4, 8'h07, "shr_b4_7");
    run_op(3'd7, 8'd15, 8'd17, "mul_15_17");
    run_op(3'd7, 8'd16, 8'd16, "mul_16_16");
    run_op(3'd2, 8'hF0, 8'h3C, "and");
    run_op(3'd4, 8'hAA, 8'hAA, "xor_zero");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random");
    end
  endtask

  task automatic test_ignore_start();
    int edges, dones;
    @(negedge clk);
    op = 3'd7; a = 8'd15; b = 8'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0; dones = 0;
    repeat (2) begin @(posedge clk); #1; edges++; if (done) dones++; end
    @(negedge clk);
    op = 3'd0; a = 8'h01; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    edges++;
    start = 1'b0;
    while (dones == 0 && edges < 40) begin
      @(posedge clk); #1; edges++;
      if (done) dones++;
    end
    checks++;
    if (dones != 1 || edges != 10 || result !== 8'hFF || cf !== 1'b0 || sf !== 1'b1) begin
      errors++;
      $display("FAIL ignore_start: got dones=%0d edge=%0d r=%h cf=%b sf=%b exp 1 10 ff 0 1",
               dones, edges, result, cf, sf);
    end
    repeat (12) begin @(posedge clk); #1; if (done) dones++; end
    checks++;
    if (dones != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_extra_done: got dones=%0d busy=%b exp 1 0", dones, busy);
    end
  endtask

  task automatic test_back_to_back();
    int edges, last, gap;
    @(negedge clk);
    op = 3'd0; a = 8'h01; b = 8'h02; start = 1'b1;
    edges = 0; last = -1;
    for (int n = 0; n < 4; n++) begin
      gap = 0;
      do begin @(posedge clk); #1; edges++; gap++; end while (!done && gap < 20);
      checks++;
      if (!done || result !== 8'h03) begin
        errors++;
        $display("FAIL b2b_done: got done=%b r=%h exp 1 03", done, result);
      end
      if (last >= 0) begin
        checks++;
        if (edges - last != 3) begin
          errors++;
          $display("FAIL b2b_gap: got %0d edges exp 3", edges - last);
        end
      end
      last = edges;
    end
    @(posedge clk); #1; edges++;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b exp 1", busy);
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_mid_reset();
    int dones;
    @(negedge clk);
    op = 3'd7; a = 8'd15; b = 8'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, cf, sf, zf} !== 13'h0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b done=%b r=%h cf=%b sf=%b zf=%b exp all 0",
               busy, done, result, cf, sf, zf);
    end
    dones = 0;
    repeat (12) begin @(posedge clk); #1; if (done) dones++; end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: got %0d dones exp 0", dones);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    run_op(3'd0, 8'd2, 8'd3, "post_reset_add");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
